// File: rtl/core_pkg.sv
// Shared encodings for the multi-core supervisor: status broadcast codes, FSM states, core limit.
// The ERR state exists only when CORE_SUPERVISOR_WDT_EN is defined.
package core_pkg;

    localparam int MAX_CORES = 4;

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_RUN  = 2'b01,
        ST_SYNC = 2'b10,
        ST_STOP = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_SYNC = 3'd2,
`ifdef CORE_SUPERVISOR_WDT_EN
        S_DONE = 3'd3,
        S_ERR  = 3'd4
`else
        S_DONE = 3'd3
`endif
    } sup_state_t;

    // Requests beyond the instantiated core count collapse onto the last real core.
    function automatic logic [1:0] clamp_core(input logic [1:0] req, input int n_cores);
        logic [1:0] res;
        if (int'(req) >= n_cores) begin
            res = 2'(n_cores - 1);
        end else begin
            res = req;
        end
        return res;
    endfunction

    function automatic logic [MAX_CORES-1:0] active_mask(input logic [1:0] end_core);
        logic [MAX_CORES-1:0] m;
        for (int i = 0; i < MAX_CORES; i++) begin
            m[i] = (i <= int'(end_core)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/core_barrier.sv
// Per-core completion barrier: rising-edge capture of end_process into done_mask,
// restricted to cores 0..end_core, with all_done including this cycle's edges.
module core_barrier
    import core_pkg::*;
#(
    parameter int N_CORES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               capture,
    input  logic               clear,
    input  logic [1:0]         end_core,
    input  logic [N_CORES-1:0] end_process,
    output logic               all_done
);

    logic [N_CORES-1:0]   prev;
    logic [N_CORES-1:0]   done_mask;
    logic [N_CORES-1:0]   rise;
    logic [N_CORES-1:0]   active;
    logic [MAX_CORES-1:0] full_mask;

    // Edge detect and barrier-complete decode.
    always_comb begin
        full_mask = active_mask(end_core);
        active    = full_mask[N_CORES-1:0];
        rise      = end_process & ~prev;
        all_done  = (((done_mask | rise) & active) == active);
    end

    // Edge history runs every cycle so levels held across RUN entry never look like edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev      <= '0;
            done_mask <= '0;
        end else begin
            prev <= end_process;
            if (clear) begin
                done_mask <= '0;
            end else if (capture) begin
                done_mask <= done_mask | (rise & active);
            end else begin
                done_mask <= done_mask;
            end
        end
    end

endmodule

// File: rtl/core_supervisor.sv
// Phase sequencer for the core array: launches runs, barriers between phases, counts cycles.
// Optional per-phase watchdog and ERR state/error port enabled by CORE_SUPERVISOR_WDT_EN.
module core_supervisor
    import core_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int WDT_CYCLES = 65535
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         active_m1,
    input  logic [3:0]         phases_m1,
    input  logic [N_CORES-1:0] end_process,
    output logic [1:0]         status,
    output logic [1:0]         end_core,
    output logic               busy,
    output logic               done,
`ifdef CORE_SUPERVISOR_WDT_EN
    output logic               error,
`endif
    output logic [3:0]         phase,
    output logic [31:0]        cycle_count
);

    if (N_CORES < 1 || N_CORES > MAX_CORES || WDT_CYCLES < 1) begin : g_bad_cfg
        $error("core_supervisor: illegal N_CORES or WDT_CYCLES");
    end

    sup_state_t  state;
    logic [3:0]  phases_lat;
    logic        launch;
    logic        clear;
    logic        capture;
    logic        all_done;
    logic [31:0] count_inc;

`ifdef CORE_SUPERVISOR_WDT_EN
    localparam logic [31:0] WDT_LIMIT = 32'(WDT_CYCLES - 1);
    logic [31:0] wdt_cnt;
`endif

    // Launch qualification, barrier control and saturating cycle increment.
    always_comb begin
        launch    = start && (state != S_RUN) && (state != S_SYNC);
        clear     = launch || (state == S_SYNC);
        capture   = (state == S_RUN);
        count_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : (cycle_count + 32'd1);
    end

    core_barrier #(
        .N_CORES (N_CORES)
    ) u_barrier (
        .clock       (clock),
        .reset       (reset),
        .capture     (capture),
        .clear       (clear),
        .end_core    (end_core),
        .end_process (end_process),
        .all_done    (all_done)
    );

    // Supervisor FSM with registered status outputs, phase and cycle counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            status      <= ST_HOLD;
            busy        <= 1'b0;
            done        <= 1'b0;
            end_core    <= 2'd0;
            phases_lat  <= 4'd0;
            phase       <= 4'd0;
            cycle_count <= 32'd0;
`ifdef CORE_SUPERVISOR_WDT_EN
            error       <= 1'b0;
            wdt_cnt     <= 32'd0;
`endif
        end else if (launch) begin
            state       <= S_RUN;
            status      <= ST_RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            end_core    <= clamp_core(active_m1, N_CORES);
            phases_lat  <= phases_m1;
            phase       <= 4'd0;
            cycle_count <= 32'd0;
`ifdef CORE_SUPERVISOR_WDT_EN
            error       <= 1'b0;
            wdt_cnt     <= 32'd0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    cycle_count <= count_inc;
                    if (all_done) begin
                        state  <= S_SYNC;
                        status <= ST_SYNC;
                    end
`ifdef CORE_SUPERVISOR_WDT_EN
                    else if (wdt_cnt == WDT_LIMIT) begin
                        state  <= S_ERR;
                        status <= ST_STOP;
                        busy   <= 1'b0;
                        error  <= 1'b1;
                    end else begin
                        wdt_cnt <= wdt_cnt + 32'd1;
                    end
`endif
                end
                S_SYNC: begin
                    cycle_count <= count_inc;
                    if (phase == phases_lat) begin
                        state  <= S_DONE;
                        status <= ST_STOP;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        state  <= S_RUN;
                        status <= ST_RUN;
                        phase  <= phase + 4'd1;
`ifdef CORE_SUPERVISOR_WDT_EN
                        wdt_cnt <= 32'd0;
`endif
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_supervisor.sv
// Self-checking bench for core_supervisor: behavioural phase/barrier model compared every cycle,
// directed scenarios with literal expectations, then randomized end_process/start/reset traffic.
module tb_core_supervisor;

    localparam int N   = 4;
    localparam int WDT = 20;
`ifdef CORE_SUPERVISOR_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_SYNC = 2, M_DONE = 3, M_ERR = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   active_m1;
    logic [3:0]   phases_m1;
    logic [N-1:0] end_process;
    logic [1:0]   status;
    logic [1:0]   end_core;
    logic         busy;
    logic         done;
    logic         error;
    logic [3:0]   phase;
    logic [31:0]  cycle_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    core_supervisor #(.N_CORES(N), .WDT_CYCLES(WDT)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .active_m1   (active_m1),
        .phases_m1   (phases_m1),
        .end_process (end_process),
        .status      (status),
        .end_core    (end_core),
        .busy        (busy),
        .done        (done),
`ifdef CORE_SUPERVISOR_WDT_EN
        .error       (error),
`endif
        .phase       (phase),
        .cycle_count (cycle_count)
    );

`ifndef CORE_SUPERVISOR_WDT_EN
    assign error = 1'b0;
`endif

    always #5 clock = ~clock;

    // Behavioural model: which cores have finished this phase, which phase, how long.
    int      mode;
    bit      got  [N];
    bit      last [N];
    int      m_end, m_last_phase, m_phase, m_wd;
    longint  m_cnt;

    always @(posedge clock) begin
        if (reset) begin
            mode = M_IDLE; m_end = 0; m_last_phase = 0; m_phase = 0; m_wd = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) begin got[i] = 1'b0; last[i] = 1'b0; end
        end else begin
            if (mode == M_RUN) begin
                bit all;
                m_cnt = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
                all = 1'b1;
                for (int i = 0; i <= m_end; i++) begin
                    if (end_process[i] && !last[i]) got[i] = 1'b1;
                    if (!got[i]) all = 1'b0;
                end
                if (all) mode = M_SYNC;
                else begin
                    m_wd++;
                    if (WDT_EN && m_wd >= WDT) mode = M_ERR;
                end
            end else if (mode == M_SYNC) begin
                m_cnt = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
                for (int i = 0; i < N; i++) got[i] = 1'b0;
                if (m_phase == m_last_phase) mode = M_DONE;
                else begin m_phase++; m_wd = 0; mode = M_RUN; end
            end else if (start) begin
                m_end = (int'(active_m1) > N - 1) ? N - 1 : int'(active_m1);
                m_last_phase = int'(phases_m1);
                m_phase = 0; m_cnt = 0; m_wd = 0;
                for (int i = 0; i < N; i++) got[i] = 1'b0;
                mode = M_RUN;
            end
            for (int i = 0; i < N; i++) last[i] = end_process[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            logic [1:0] es;
            es = (mode == M_RUN) ? 2'b01 : (mode == M_SYNC) ? 2'b10 :
                 (mode == M_IDLE) ? 2'b00 : 2'b11;
            check("status", 32'(status), 32'(es));
            check("busy", 32'(busy), 32'((mode == M_RUN) || (mode == M_SYNC)));
            check("done", 32'(done), 32'(mode == M_DONE));
            check("error", 32'(error), 32'(mode == M_ERR));
            check("phase", 32'(phase), 32'(m_phase));
            check("end_core", 32'(end_core), 32'(m_end));
            check("cycle_count", cycle_count, m_cnt[31:0]);
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; active_m1 = 2'd0; phases_m1 = 4'd0; end_process = '0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_status", 32'(status), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        reset = 1'b0;
        step();

        // Single phase, four cores rising at 5,7,7,9.
        active_m1 = 2'd3; phases_m1 = 4'd0;
        for (int c = 0; c <= 10; c++) begin
            start = (c == 0);
            end_process[0] = (c >= 5);
            end_process[1] = (c >= 7);
            end_process[2] = (c >= 7);
            end_process[3] = (c >= 9);
            step();
            if (c == 8)  check("t1_run", 32'(status), 32'd1);
            if (c == 9)  check("t1_sync", 32'(status), 32'd2);
            if (c == 10) begin
                check("t1_stop", 32'(status), 32'd3);
                check("t1_done", 32'(done), 32'd1);
                check("t1_count", cycle_count, 32'd10);
            end
        end
        end_process = '0; step(); step();

        // Inactive core ignored.
        active_m1 = 2'd1; phases_m1 = 4'd0;
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0);
            end_process[3] = (c >= 1);
            end_process[1:0] = (c >= 4) ? 2'b11 : 2'b00;
            step();
            if (c == 3) check("t2_hold", 32'(status), 32'd1);
            if (c == 4) check("t2_sync", 32'(status), 32'd2);
            if (c == 5) check("t2_stop", 32'(status), 32'd3);
        end
        end_process = '0; step();

        // Three phases, cores drop during SYNC.
        active_m1 = 2'd1; phases_m1 = 4'd2; start = 1'b1; step(); start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            end_process = 4'b0011; step();
            check("t3_sync", 32'(status), 32'd2);
            check("t3_phase", 32'(phase), 32'(p));
            end_process = 4'b0000; step();
            check("t3_after", 32'(status), (p < 2) ? 32'd1 : 32'd3);
        end
        check("t3_final_phase", 32'(phase), 32'd2);
        check("t3_final_done", 32'(done), 32'd1);

        // Stale level on core 0 before launch.
        end_process = 4'b0001; step(); step();
        active_m1 = 2'd0; phases_m1 = 4'd0; start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check("t4_stale", 32'(status), 32'd1);
        end_process = 4'b0000; step();
        check("t4_low", 32'(status), 32'd1);
        end_process = 4'b0001; step();
        check("t4_sync", 32'(status), 32'd2);
        end_process = 4'b0000; step();

        // Reset in RUN at phase 1, then relaunch.
        active_m1 = 2'd0; phases_m1 = 4'd2; start = 1'b1; step(); start = 1'b0;
        end_process = 4'b0001; step();
        end_process = 4'b0000; step();
        check("t5_phase1", 32'(phase), 32'd1);
        reset = 1'b1; step();
        check("t5_status", 32'(status), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_phase", 32'(phase), 32'd0);
        check("t5_count", cycle_count, 32'd0);
        reset = 1'b0; active_m1 = 2'd2; start = 1'b1; step(); start = 1'b0;
        check("t5_relaunch", 32'(status), 32'd1);
        check("t5_end_core", 32'(end_core), 32'd2);

`ifdef CORE_SUPERVISOR_WDT_EN
        // Watchdog with nobody finishing.
        reset = 1'b1; step(); reset = 1'b0;
        active_m1 = 2'd0; phases_m1 = 4'd0; end_process = '0;
        for (int c = 0; c <= 20; c++) begin
            start = (c == 0);
            step();
            if (c == 19) check("t6_run", 32'(status), 32'd1);
            if (c == 20) begin
                check("t6_err_status", 32'(status), 32'd3);
                check("t6_error", 32'(error), 32'd1);
                check("t6_busy", 32'(busy), 32'd0);
            end
        end
        start = 1'b1; step(); start = 1'b0;
        check("t6_restart", 32'(status), 32'd1);
`endif

        // Randomized runs.
        reset = 1'b1; step(); reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            active_m1 = 2'($urandom_range(0, 3));
            phases_m1 = 4'($urandom_range(0, 3));
            start = 1'b1; step(); start = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 3) == 0)
                    end_process[$urandom_range(0, N - 1)] ^= 1'b1;
                start = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 199) == 0);
                step();
                start = 1'b0; reset = 1'b0;
                if (mode == M_DONE || mode == M_ERR || mode == M_IDLE) break;
            end
            end_process = '0; step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
